wb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares a single wb_ram-style slave between two requesters, e.g. CPU (m0) and a DMA/video fetch engine (m1).
- Issues exactly one single-cycle slave strobe per granted transaction, which suits slaves that acknowledge every strobed cycle.
- Latches write data and read data, and returns a registered ack to the winning master only.
- Uses round-robin arbitration and a watchdog timeout, so a missing slave ack cannot hang the bus.

---
 rtl/wb_arbiter2_if.sv | 15 +
 rtl/wb_arbiter2.sv | 113 +++++++++++
 tb/tb_wb_arbiter2.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: one Wishbone link; master drives the request side, slave drives the response side.
interface wb_arbiter2_if #(
    parameter int DW = 8,
    parameter int AW = 9
);
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdat;
    modport master(output stb, we, adr, wdat, input ack, err, rdat);
    modport slave(input stb, we, adr, wdat, output ack, err, rdat);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master Wishbone arbiter with one single-cycle slave strobe per grant
// and a watchdog that completes with err when the slave never acks.
module wb_arbiter2 #(
    parameter int WB_DATA_WIDTH  = 8,
    parameter int WB_ADDR_WIDTH  = 9,
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic           clk_i,
    input logic           rst_i,
    wb_arbiter2_if.slave  m0,
    wb_arbiter2_if.slave  m1,
    wb_arbiter2_if.master s
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t                   r_state, w_state;
    logic                     r_grant, w_grant, r_last, w_last;
    logic [7:0]               r_cnt, w_cnt;
    logic                     r_stb, w_stb, r_we, w_we;
    logic [WB_ADDR_WIDTH-1:0] r_adr, w_adr;
    logic [WB_DATA_WIDTH-1:0] r_dat, w_dat, r_rd0, w_rd0, r_rd1, w_rd1;
    logic                     r_ack0, w_ack0, r_ack1, w_ack1, r_err0, w_err0, r_err1, w_err1;
    logic                     w_timeout;
    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_last    = r_last;
        w_cnt     = r_cnt;
        w_stb     = 1'b0;
        w_we      = r_we;
        w_adr     = r_adr;
        w_dat     = r_dat;
        w_rd0     = r_rd0;
        w_rd1     = r_rd1;
        w_ack0    = 1'b0;
        w_ack1    = 1'b0;
        w_err0    = 1'b0;
        w_err1    = 1'b0;
        w_timeout = r_cnt == 8'(TIMEOUT_CYCLES - 1);
        case (r_state)
            IDLE: if (m0.stb || m1.stb) begin
                // on a tie the master that did not win last time gets the bus
                w_grant = (m0.stb && m1.stb) ? ~r_last : m1.stb;
                w_last  = w_grant;
                w_we    = w_grant ? m1.we : m0.we;
                w_adr   = w_grant ? m1.adr : m0.adr;
                w_dat   = w_grant ? m1.wdat : m0.wdat;
                w_stb   = 1'b1;
                w_state = ISSUE;
            end
            ISSUE: begin
                w_cnt   = 8'd0;
                w_state = WAIT;
            end
            WAIT: if (s.ack || w_timeout) begin
                if (s.ack && !r_we) begin
                    w_rd0 = r_grant ? r_rd0 : s.rdat;
                    w_rd1 = r_grant ? s.rdat : r_rd1;
                end
                w_ack0  = !r_grant;
                w_ack1  = r_grant;
                w_err0  = !r_grant && !s.ack;
                w_err1  = r_grant && !s.ack;
                w_state = DONE;
            end else begin
                w_cnt = r_cnt + 8'd1;
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
            r_stb   <= w_stb;
            r_we    <= w_we;
            r_adr   <= w_adr;
            r_dat   <= w_dat;
            r_rd0   <= w_rd0;
            r_rd1   <= w_rd1;
            r_ack0  <= w_ack0;
            r_ack1  <= w_ack1;
            r_err0  <= w_err0;
            r_err1  <= w_err1;
        end
    end
    assign s.stb   = r_stb;
    assign s.we    = r_we;
    assign s.adr   = r_adr;
    assign s.wdat  = r_dat;
    assign m0.ack  = r_ack0;
    assign m0.err  = r_err0;
    assign m0.rdat = r_rd0;
    assign m1.ack  = r_ack1;
    assign m1.err  = r_err1;
    assign m1.rdat = r_rd1;
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios against a one-cycle RAM slave model.
module tb_wb_arbiter2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic       ack_en = 1'b1;
    logic       pl_en = 1'b0;
    logic [8:0] pl_adr = '0;
    logic [7:0] pl_dat = '0;
    logic [7:0] mem [0:511];
    wb_arbiter2_if #(.DW(8), .AW(9)) m0_if ();
    wb_arbiter2_if #(.DW(8), .AW(9)) m1_if ();
    wb_arbiter2_if #(.DW(8), .AW(9)) s_if ();
    wb_arbiter2 #(.WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(9), .TIMEOUT_CYCLES(15)) dut (
        .clk_i(clk), .rst_i(rst), .m0(m0_if), .m1(m1_if), .s(s_if)
    );
    always #5 clk = ~clk;
    assign s_if.err = 1'b0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_adr] <= pl_dat;
        else if (s_if.stb && s_if.we) mem[s_if.adr] <= s_if.wdat;
        s_if.ack  <= s_if.stb && ack_en;
        s_if.rdat <= mem[s_if.adr];
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic preload(input logic [8:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_adr = a; pl_dat = d;
        cyc();
        pl_en = 1'b0;
    endtask
    task automatic test_reset();
        checks++; if (s_if.stb !== 1'b0) begin failures++; $display("FAIL reset_s_stb got=%b exp=0", s_if.stb); end
        checks++; if (s_if.we !== 1'b0) begin failures++; $display("FAIL reset_s_we got=%b exp=0", s_if.we); end
        checks++; if (s_if.adr !== 9'h000) begin failures++; $display("FAIL reset_s_adr got=%h exp=000", s_if.adr); end
        checks++; if (s_if.wdat !== 8'h00) begin failures++; $display("FAIL reset_s_dat got=%h exp=00", s_if.wdat); end
        checks++; if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0) begin failures++; $display("FAIL reset_ack_err got=%b exp=0000", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}); end
        checks++; if ({m0_if.rdat, m1_if.rdat} !== 16'h0) begin failures++; $display("FAIL reset_rdat got=%h exp=0000", {m0_if.rdat, m1_if.rdat}); end
    endtask
    task automatic test_single_read();
        rst = 1'b0; m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 9'h012; m0_if.wdat = 8'h00;
        cyc();
        checks++; if (s_if.stb !== 1'b1) begin failures++; $display("FAIL sr_stb_c1 got=%b exp=1", s_if.stb); end
        checks++; if (s_if.adr !== 9'h012 || s_if.we !== 1'b0) begin failures++; $display("FAIL sr_adr_we got=%h/%b exp=012/0", s_if.adr, s_if.we); end
        cyc();
        checks++; if (s_if.stb !== 1'b0 || m0_if.ack !== 1'b0) begin failures++; $display("FAIL sr_c2 stb/ack got=%b%b exp=00", s_if.stb, m0_if.ack); end
        cyc();
        checks++; if (m0_if.ack !== 1'b1 || m0_if.err !== 1'b0) begin failures++; $display("FAIL sr_c3 ack/err got=%b%b exp=10", m0_if.ack, m0_if.err); end
        checks++; if (m0_if.rdat !== 8'hA5) begin failures++; $display("FAIL sr_rdat got=%h exp=a5", m0_if.rdat); end
        checks++; if (m1_if.ack !== 1'b0 || s_if.stb !== 1'b0) begin failures++; $display("FAIL sr_c3 m1ack/stb got=%b%b exp=00", m1_if.ack, s_if.stb); end
        m0_if.stb = 1'b0;
        cyc();
        checks++; if (m0_if.ack !== 1'b0) begin failures++; $display("FAIL sr_c4 ack got=%b exp=0", m0_if.ack); end
    endtask
    task automatic test_write_read();
        m1_if.stb = 1'b1; m1_if.we = 1'b1; m1_if.adr = 9'h1FF; m1_if.wdat = 8'h3C;
        cyc();
        checks++; if ({s_if.stb, s_if.we} !== 2'b11 || s_if.wdat !== 8'h3C || s_if.adr !== 9'h1FF) begin failures++; $display("FAIL wr_strobe got=%b%b %h %h exp=11 3c 1ff", s_if.stb, s_if.we, s_if.wdat, s_if.adr); end
        cyc();
        cyc();
        checks++; if ({m1_if.ack, m1_if.err, m0_if.ack} !== 3'b100) begin failures++; $display("FAIL wr_ack got=%b exp=100", {m1_if.ack, m1_if.err, m0_if.ack}); end
        m1_if.we = 1'b0;
        cyc();
        checks++; if (s_if.stb !== 1'b0) begin failures++; $display("FAIL wr_idle_stb got=%b exp=0", s_if.stb); end
        cyc();
        checks++; if ({s_if.stb, s_if.we} !== 2'b10 || s_if.adr !== 9'h1FF) begin failures++; $display("FAIL rd_strobe got=%b%b %h exp=10 1ff", s_if.stb, s_if.we, s_if.adr); end
        cyc();
        cyc();
        checks++; if (m1_if.ack !== 1'b1 || m1_if.rdat !== 8'h3C) begin failures++; $display("FAIL rd_m1 got=%b %h exp=1 3c", m1_if.ack, m1_if.rdat); end
        checks++; if (m0_if.rdat !== 8'hA5) begin failures++; $display("FAIL rd_m0_hold got=%h exp=a5", m0_if.rdat); end
        m1_if.stb = 1'b0;
        cyc();
    endtask
    task automatic test_simultaneous();
        rst = 1'b1;
        m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 9'h012;
        m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.adr = 9'h1FF;
        cyc();
        cyc();
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            checks++; if (m0_if.ack !== (c % 8 == 3)) begin failures++; $display("FAIL rr_m0_ack c=%0d got=%b exp=%b", c, m0_if.ack, c % 8 == 3); end
            checks++; if (m1_if.ack !== (c % 8 == 7)) begin failures++; $display("FAIL rr_m1_ack c=%0d got=%b exp=%b", c, m1_if.ack, c % 8 == 7); end
            if (c % 4 == 1) begin
                checks++; if (s_if.stb !== 1'b1 || s_if.adr !== ((c % 8 == 1) ? 9'h012 : 9'h1FF)) begin failures++; $display("FAIL rr_grant c=%0d got=%b %h", c, s_if.stb, s_if.adr); end
            end
        end
        m0_if.stb = 1'b0; m1_if.stb = 1'b0;
        cyc();
        checks++; if ({m0_if.rdat, m1_if.rdat} !== 16'hA53C) begin failures++; $display("FAIL rr_rdat got=%h exp=a53c", {m0_if.rdat, m1_if.rdat}); end
    endtask
    task automatic test_timeout();
        ack_en = 1'b0;
        m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 9'h055;
        cyc();
        for (int c = 2; c <= 16; c++) begin
            cyc();
            checks++; if (m0_if.ack !== 1'b0) begin failures++; $display("FAIL to_early_ack c=%0d got=%b exp=0", c, m0_if.ack); end
        end
        cyc();
        checks++; if ({m0_if.ack, m0_if.err} !== 2'b11) begin failures++; $display("FAIL to_ack_err got=%b exp=11", {m0_if.ack, m0_if.err}); end
        checks++; if (m0_if.rdat !== 8'hA5) begin failures++; $display("FAIL to_rdat_hold got=%h exp=a5", m0_if.rdat); end
        checks++; if ({m1_if.ack, m1_if.err} !== 2'b00) begin failures++; $display("FAIL to_m1 got=%b exp=00", {m1_if.ack, m1_if.err}); end
        m0_if.stb = 1'b0; ack_en = 1'b1;
        cyc();
        checks++; if ({m0_if.ack, m0_if.err} !== 2'b00) begin failures++; $display("FAIL to_clear got=%b exp=00", {m0_if.ack, m0_if.err}); end
        m0_if.stb = 1'b1;
        cyc();
        cyc();
        cyc();
        checks++; if ({m0_if.ack, m0_if.err} !== 2'b10 || m0_if.rdat !== 8'h77) begin failures++; $display("FAIL to_recover got=%b %h exp=10 77", {m0_if.ack, m0_if.err}, m0_if.rdat); end
        m0_if.stb = 1'b0;
        cyc();
    endtask
    task automatic test_late_request();
        m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 9'h012;
        cyc();
        cyc();
        m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.adr = 9'h1FF;
        cyc();
        checks++; if ({m0_if.ack, m1_if.ack} !== 2'b10) begin failures++; $display("FAIL late_c3 got=%b exp=10", {m0_if.ack, m1_if.ack}); end
        m0_if.stb = 1'b0;
        cyc();
        checks++; if ({s_if.stb, m1_if.ack} !== 2'b00) begin failures++; $display("FAIL late_c4 got=%b exp=00", {s_if.stb, m1_if.ack}); end
        cyc();
        checks++; if (s_if.stb !== 1'b1 || s_if.adr !== 9'h1FF) begin failures++; $display("FAIL late_c5 got=%b %h exp=1 1ff", s_if.stb, s_if.adr); end
        cyc();
        cyc();
        checks++; if ({m1_if.ack, m0_if.ack} !== 2'b10) begin failures++; $display("FAIL late_c7 got=%b exp=10", {m1_if.ack, m0_if.ack}); end
        m1_if.stb = 1'b0;
        cyc();
    endtask
    task automatic test_reset_midop();
        ack_en = 1'b0;
        m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 9'h012;
        cyc();
        cyc();
        cyc();
        rst = 1'b1; m0_if.stb = 1'b0;
        cyc();
        checks++; if ({s_if.stb, m0_if.ack, m1_if.ack} !== 3'b000) begin failures++; $display("FAIL rm_outputs got=%b exp=000", {s_if.stb, m0_if.ack, m1_if.ack}); end
        checks++; if (m0_if.rdat !== 8'h00 || s_if.adr !== 9'h000) begin failures++; $display("FAIL rm_regs got=%h %h exp=00 000", m0_if.rdat, s_if.adr); end
        rst = 1'b0; ack_en = 1'b1;
        m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.adr = 9'h1FF;
        cyc();
        checks++; if ({s_if.stb, m0_if.ack} !== 2'b10) begin failures++; $display("FAIL rm_c1 got=%b exp=10", {s_if.stb, m0_if.ack}); end
        cyc();
        checks++; if ({m1_if.ack, m0_if.ack} !== 2'b00) begin failures++; $display("FAIL rm_c2 got=%b exp=00", {m1_if.ack, m0_if.ack}); end
        cyc();
        checks++; if ({m1_if.ack, m0_if.ack} !== 2'b10 || m1_if.rdat !== 8'h3C) begin failures++; $display("FAIL rm_c3 got=%b %h exp=10 3c", {m1_if.ack, m0_if.ack}, m1_if.rdat); end
        m1_if.stb = 1'b0;
        cyc();
    endtask
    initial begin
        m0_if.stb = 1'b0; m0_if.we = 1'b0; m0_if.adr = '0; m0_if.wdat = '0;
        m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.adr = '0; m1_if.wdat = '0;
        #1;
        preload(9'h012, 8'hA5);
        preload(9'h055, 8'h77);
        cyc();
        test_reset();
        test_single_read();
        test_write_read();
        test_simultaneous();
        test_timeout();
        test_late_request();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
